// File: rtl/cbc_d_stream.sv
// AES-128 CBC decryption stream: valid/ready in and out, one block per cycle, one-deep output register.
// Define CBC_BLKCNT_EN to add the 17-bit blk_cnt output counting consumed plaintext blocks.

module cbc_d (
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic [127:0] pt
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Field inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c, input logic [127:0] k);
    logic [31:0]  w [0:43];
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [31:0]  tmp;
    logic [7:0]   rcon;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = c[127-8*b -: 8] ^ w[40 + b/4][31-8*(b%4) -: 8];
    // Bytes are column-major: index = row + 4*col. Shift/sub merged into one gather.
    for (int r = 9; r >= 0; r--) begin
      for (int b = 0; b < 16; b++)
        t[b] = inv_sbox(s[(b%4) + 4*(((b/4) - (b%4) + 4) % 4)]) ^ w[4*r + b/4][31-8*(b%4) -: 8];
      for (int col = 0; col < 4; col++) begin
        if (r != 0) begin
          s[4*col]   = gmul(t[4*col], 8'd14) ^ gmul(t[4*col+1], 8'd11) ^ gmul(t[4*col+2], 8'd13) ^ gmul(t[4*col+3], 8'd9);
          s[4*col+1] = gmul(t[4*col], 8'd9)  ^ gmul(t[4*col+1], 8'd14) ^ gmul(t[4*col+2], 8'd11) ^ gmul(t[4*col+3], 8'd13);
          s[4*col+2] = gmul(t[4*col], 8'd13) ^ gmul(t[4*col+1], 8'd9)  ^ gmul(t[4*col+2], 8'd14) ^ gmul(t[4*col+3], 8'd11);
          s[4*col+3] = gmul(t[4*col], 8'd11) ^ gmul(t[4*col+1], 8'd13) ^ gmul(t[4*col+2], 8'd9)  ^ gmul(t[4*col+3], 8'd14);
        end else begin
          for (int j = 0; j < 4; j++) s[4*col+j] = t[4*col+j];
        end
      end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  assign pt = aes_dec(ct, key);

endmodule

module cbc_d_stream (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ct_data,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] pt_data,
  output logic         armed
`ifdef CBC_BLKCNT_EN
  ,
  output logic [16:0]  blk_cnt
`endif
);

  typedef enum logic [1:0] {NOCFG, RUN, STALL} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [127:0] iv_reg;
  logic [127:0] dec_data;
  logic         accept;

  cbc_d u_core (
    .ct  (ct_data),
    .key (key_reg),
    .pt  (dec_data)
  );

  // cfg_load blocks acceptance so a new key/IV never mixes with an in-flight block.
  assign ct_ready = (state != NOCFG) && !cfg_load && (!pt_valid || pt_ready);
  assign accept   = ct_valid && ct_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NOCFG;
      key_reg  <= '0;
      iv_reg   <= '0;
      pt_data  <= '0;
      pt_valid <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (cfg_load) begin
        key_reg <= key_in;
        iv_reg  <= iv_in;
        armed   <= 1'b1;
      end else if (accept) begin
        iv_reg  <= ct_data;
      end
      if (accept) begin
        pt_data  <= dec_data ^ iv_reg;
        pt_valid <= 1'b1;
      end else if (pt_ready) begin
        pt_valid <= 1'b0;
      end
      case (state)
        NOCFG:   if (cfg_load) state <= RUN;
        RUN:     if (pt_valid && !pt_ready) state <= STALL;
        STALL:   if (pt_ready) state <= RUN;
        default: state <= NOCFG;
      endcase
    end
  end

`ifdef CBC_BLKCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       blk_cnt <= '0;
    else if (cfg_load)             blk_cnt <= '0;
    else if (pt_valid && pt_ready) blk_cnt <= blk_cnt + 17'd1;
  end
`endif

endmodule

// File: tb/tb_cbc_d_stream.sv
// Bench for cbc_d_stream: NIST CBC vectors, handshake corner cases, and random streams
// checked against a CBC-encryption model (plaintext chosen first, ciphertext derived).

module tb_cbc_d_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         armed;
`ifdef CBC_BLKCNT_EN
  logic [16:0]  blk_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sbox_t [256];

  localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  cbc_d_stream dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .key_in   (key_in),
    .iv_in    (iv_in),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_data  (ct_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_data  (pt_data),
    .armed    (armed)
`ifdef CBC_BLKCNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   st [16];
    logic [7:0]   tm [16];
    logic [7:0]   rk [16];
    logic [7:0]   rc;
    logic [7:0]   t0, t1, t2, t3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      rk[i] = key[127-8*i -: 8];
      st[i] = pt[127-8*i -: 8] ^ rk[i];
    end
    rc = 8'h01;
    for (int round = 1; round <= 10; round++) begin
      t0 = sbox_t[rk[13]] ^ rc;
      t1 = sbox_t[rk[14]];
      t2 = sbox_t[rk[15]];
      t3 = sbox_t[rk[12]];
      rk[0] ^= t0; rk[1] ^= t1; rk[2] ^= t2; rk[3] ^= t3;
      for (int i = 4; i < 16; i++) rk[i] ^= rk[i-4];
      rc = mul2(rc);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tm[r+4*c] = sbox_t[st[r + 4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (round < 10) begin
          st[4*c]   = mul2(tm[4*c]) ^ mul2(tm[4*c+1]) ^ tm[4*c+1] ^ tm[4*c+2] ^ tm[4*c+3];
          st[4*c+1] = tm[4*c] ^ mul2(tm[4*c+1]) ^ mul2(tm[4*c+2]) ^ tm[4*c+2] ^ tm[4*c+3];
          st[4*c+2] = tm[4*c] ^ tm[4*c+1] ^ mul2(tm[4*c+2]) ^ mul2(tm[4*c+3]) ^ tm[4*c+3];
          st[4*c+3] = mul2(tm[4*c]) ^ tm[4*c] ^ tm[4*c+1] ^ tm[4*c+2] ^ mul2(tm[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) st[4*c+j] = tm[4*c+j];
        end
      end
      for (int i = 0; i < 16; i++) st[i] ^= rk[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random handshakes with a fresh key/IV; starts and ends with the output register empty.
  task automatic random_stream(input int nblocks);
    logic [127:0] mkey, miv, blk_ct, blk_pt, exp_pt;
    logic         have_blk, exp_pv, exp_rdy, acc;
    int           sent, cycles;
    mkey = rand128();
    miv  = rand128();
    cfg_load = 1'b1; key_in = mkey; iv_in = miv; ct_valid = 1'b0; pt_ready = 1'b0;
    tick();
    cfg_load = 1'b0;
    have_blk = 1'b0; exp_pv = 1'b0; exp_pt = '0; blk_ct = '0; blk_pt = '0;
    sent = 0; cycles = 0;
    while ((sent < nblocks || have_blk || exp_pv) && cycles < 4000) begin
      if (!have_blk && sent < nblocks) begin
        blk_pt   = rand128();
        blk_ct   = aes_enc(blk_pt ^ miv, mkey);
        miv      = blk_ct;
        have_blk = 1'b1;
      end
      ct_valid = have_blk && ($urandom_range(0, 3) != 0);
      ct_data  = have_blk ? blk_ct : rand128();
      pt_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !exp_pv || pt_ready;
      check("rand_ct_ready", ct_ready, exp_rdy);
      check("rand_pt_valid", pt_valid, exp_pv);
      if (exp_pv) check("rand_pt_data", pt_data, exp_pt);
      acc = ct_valid && exp_rdy;
      tick();
      if (acc) begin
        exp_pv   = 1'b1;
        exp_pt   = blk_pt;
        have_blk = 1'b0;
        sent++;
      end else if (pt_ready) begin
        exp_pv = 1'b0;
      end
      cycles++;
    end
    if (cycles >= 4000) begin
      errors++;
      $display("[TB] FAIL rand_timeout: sent %0d of %0d", sent, nblocks);
    end
    ct_valid = 1'b0;
    pt_ready = 1'b0;
  endtask

  initial begin
    build_sbox();
    vecs[0] = '{ct: 128'h7649abac8119b246cee98e9b12e9197d, pt: 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[1] = '{ct: 128'h5086cb9b507219ee95db113a917678b2, pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[2] = '{ct: 128'h73bed6b8e3c1743b7116e69e22229516, pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vecs[3] = '{ct: 128'h3ff1caa1681fac09120eca307586e1a7, pt: 128'hf69f2445df4f9b17ad2b417be66c3710};

    rst = 1'b1; cfg_load = 1'b0; key_in = '0; iv_in = '0;
    ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b0;
    #2;
    check("rst_pt_valid", pt_valid, 0);
    check("rst_armed", armed, 0);
    check("rst_ct_ready", ct_ready, 0);
    check("rst_pt_data", pt_data, 0);
    tick(); tick();
    rst = 1'b0;

    // Traffic before any configuration is refused.
    ct_valid = 1'b1; ct_data = vecs[0].ct; pt_ready = 1'b1;
    repeat (3) begin
      tick();
      check("nocfg_ct_ready", ct_ready, 0);
      check("nocfg_pt_valid", pt_valid, 0);
      check("nocfg_armed", armed, 0);
    end

    // Configure while ct_valid is high: the block must wait.
    cfg_load = 1'b1; key_in = NIST_KEY; iv_in = NIST_IV;
    #1;
    check("cfg_ct_ready", ct_ready, 0);
    tick();
    cfg_load = 1'b0;
    check("cfg_armed", armed, 1);
    check("cfg_pt_valid", pt_valid, 0);

    // NIST vectors back-to-back.
    for (int i = 0; i < 4; i++) begin
      ct_valid = 1'b1; ct_data = vecs[i].ct; pt_ready = 1'b1;
      #1;
      check("vec_ct_ready", ct_ready, 1);
      tick();
      check("vec_pt_valid", pt_valid, 1);
      check("vec_pt_data", pt_data, vecs[i].pt);
    end
    ct_valid = 1'b0;
    tick();
    check("drain_pt_valid", pt_valid, 0);

    // Backpressure for five cycles.
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ct_valid = 1'b1; ct_data = vecs[0].ct; pt_ready = 1'b0;
    tick();
    check("stall_first", pt_data, vecs[0].pt);
    ct_data = vecs[1].ct;
    repeat (5) begin
      #1;
      check("stall_ct_ready", ct_ready, 0);
      tick();
      check("stall_pt_valid", pt_valid, 1);
      check("stall_pt_hold", pt_data, vecs[0].pt);
    end
    pt_ready = 1'b1;
    #1;
    check("release_ct_ready", ct_ready, 1);
    tick();
    check("release_pt_data", pt_data, vecs[1].pt);

    // Reconfigure while an output is pending: it must survive.
    ct_valid = 1'b0; pt_ready = 1'b0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("cfgpend_pt_valid", pt_valid, 1);
    check("cfgpend_pt_data", pt_data, vecs[1].pt);

    // cfg_load and ct_valid together: accepted one cycle later under the new IV.
    cfg_load = 1'b1; ct_valid = 1'b1; ct_data = vecs[0].ct; pt_ready = 1'b1;
    #1;
    check("coinc_ct_ready", ct_ready, 0);
    tick();
    cfg_load = 1'b0;
    check("coinc_pt_valid", pt_valid, 0);
    #1;
    check("coinc_next_ready", ct_ready, 1);
    tick();
    check("coinc_pt_data", pt_data, vecs[0].pt);
    ct_valid = 1'b0;
    tick();

    random_stream(150);
    random_stream(150);

    // Asynchronous reset with a block pending.
    ct_valid = 1'b1; ct_data = rand128(); pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    tick();
    check("pre_rst_pt_valid", pt_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_pt_valid", pt_valid, 0);
    check("arst_armed", armed, 0);
    check("arst_pt_data", pt_data, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ct_ready", ct_ready, 0);

`ifdef CBC_BLKCNT_EN
    cfg_load = 1'b1; key_in = NIST_KEY; iv_in = NIST_IV; ct_valid = 1'b0; pt_ready = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("cnt_zero", blk_cnt, 0);
    ct_valid = 1'b1; ct_data = '0;
    repeat (65536) tick();
    ct_valid = 1'b0;
    tick();
    check("cnt_65536", blk_cnt, 17'd65536);
    ct_valid = 1'b1;
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    check("cnt_arst", blk_cnt, 0);
    check("cnt_arst_pv", pt_valid, 0);
    tick();
    rst = 1'b0;
    ct_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbc_d_stream.md
CBC_D_STREAM -- requirements
Module: cbc_d_stream

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port cfg_load, input, 1 bit: one-cycle pulse that loads key_in and iv_in.
REQ-004 SHALL have port key_in, input, 128 bits: AES-128 key, sampled on cfg_load.
REQ-005 SHALL have port iv_in, input, 128 bits: initial chaining value, sampled on cfg_load.
REQ-006 SHALL have port ct_valid, input, 1 bit: ciphertext block offered.
REQ-007 SHALL have port ct_ready, output, 1 bit: block accepted this edge when ct_valid is also high.
REQ-008 SHALL have port ct_data, input, 128 bits: ciphertext block.
REQ-009 SHALL have port pt_valid, output, 1 bit: plaintext block available.
REQ-010 SHALL have port pt_ready, input, 1 bit: downstream consumes pt_data this edge.
REQ-011 SHALL have port pt_data, output, 128 bits: decrypted plaintext block.
REQ-012 SHALL have port armed, output, 1 bit: high once key and IV are loaded.

Function
REQ-013 SHALL implement FSM states NOCFG, RUN and STALL; reset enters NOCFG.
REQ-014 SHALL leave NOCFG for RUN on cfg_load; ct_ready SHALL be 0 in NOCFG.
REQ-015 SHALL load cfg_load into key_reg and iv_reg at the same edge, in any state.
REQ-016 SHALL drive ct_ready = (state != NOCFG) and !cfg_load and (!pt_valid or pt_ready).
REQ-017 On acceptance, SHALL register pt_data = AES128_dec(ct_data, key_reg) XOR iv_reg, using the existing cbc_d core combinationally. At the same edge it SHALL set iv_reg = ct_data and pt_valid = 1.
REQ-018 SHALL give a latency of exactly 1 cycle: a block accepted at edge N has pt_valid high after edge N.
REQ-019 SHALL hold pt_data and pt_valid stable while pt_valid=1 and pt_ready=0. The FSM enters STALL in this condition and returns to RUN on pt_ready.
REQ-020 SHALL clear pt_valid on pt_ready when no new block is accepted at the same edge.
REQ-021 Simultaneous pt_ready and ct_valid SHALL consume the old output and accept the new block at one edge, sustaining 1 block/cycle.
REQ-022 If cfg_load coincides with ct_valid, SHALL give cfg_load priority; the block is not accepted and ct_ready is 0.
REQ-023 cfg_load while pt_valid=1 SHALL keep the pending pt_data unchanged until it is consumed.
REQ-024 SHALL drive armed=1 in RUN and STALL, and 0 in NOCFG.

Reset
REQ-025 On rst, SHALL immediately clear state to NOCFG, key_reg, iv_reg and pt_data to 0, and pt_valid and armed to 0.
REQ-026 rst mid-stream SHALL discard any pending block; cfg_load is required before further traffic.

Configuration
REQ-027 With CBC_BLKCNT_EN defined, SHALL add output blk_cnt, 17 bits. blk_cnt is cleared by rst and cfg_load, increments on each pt_valid and pt_ready handshake, and wraps 131071->0.
REQ-028 Without CBC_BLKCNT_EN, SHALL have neither the blk_cnt port nor the counter logic; all other behaviour is identical.

Verification
REQ-029 Reset, then cfg_load with key 2b7e151628aed2a6abf7158809cf4f3c and iv 000102030405060708090a0b0c0d0e0f. Then present ct 7649abac8119b246cee98e9b12e9197d. Required: pt_data 6bc1bee22e409f96e93d7e117393172a one cycle later.
REQ-030 Follow REQ-029 with ct 5086cb9b507219ee95db113a917678b2 back-to-back with pt_ready=1. Required: pt_data ae2d8a571e03ac9c9eb76fac45af8e51, and ct_ready stays high throughout.
REQ-031 Hold pt_ready=0 for 5 cycles with ct_valid=1. Required: ct_ready=0, and pt_data stable at its first value; release yields the correct next block.
REQ-032 ct_valid=1 before any cfg_load. Required: ct_ready=0, pt_valid=0 and armed=0.
REQ-033 Assert cfg_load and ct_valid in the same cycle. Required: block not accepted; it is accepted in the following cycle and decrypted with the new iv.
REQ-034 With CBC_BLKCNT_EN, stream 65536 blocks. Required: blk_cnt=65536; rst mid-stream returns blk_cnt=0 and pt_valid=0 asynchronously.
